// File: rtl/fp_cvt_w_stage.sv
// Issue/collect wrapper for a fixed-latency FP32->Int33 converter (RISC-V fcvt.w[u].s, RTZ).
// Classifies at accept, carries sideband alongside the converter, saturates and buffers results under credit control.
module fp_cvt_w_stage #(
    parameter int LATENCY    = 3,
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic             in_unsig,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      cvt_a,
    input  logic [32:0]      cvt_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int SB_W  = 1 + 3 + TAG_W;
    localparam int ENT_W = 1 + 32 + TAG_W;

    localparam logic [2:0] CLS_OK      = 3'd0;
    localparam logic [2:0] CLS_NAN     = 3'd1;
    localparam logic [2:0] CLS_POS     = 3'd2;
    localparam logic [2:0] CLS_NEG     = 3'd3;
    localparam logic [2:0] CLS_NEG_LT1 = 3'd4;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic              accept, push, pop, fifo_empty;
    logic              a_s, a_nan;
    logic [7:0]        a_e;
    logic [2:0]        in_cls;
    logic [AW:0]       count_q, count_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LATENCY-1:0] vld_q;
    logic [SB_W-1:0]   sb_q [LATENCY];
    logic              p_uns;
    logic [2:0]        p_cls;
    logic [TAG_W-1:0]  p_tag;
    logic [31:0]       push_data;
    logic              push_nv;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  head;
    logic              unused_q_msb;

    assign cvt_a        = in_a;
    assign unused_q_msb = cvt_q[32];

    // Credits cover both the converter pipe and the FIFO, so a push can never overflow.
    assign in_ready = areset_n & (count_q < DEPTH_C);
    assign accept   = in_valid & in_ready;

    assign a_s   = in_a[31];
    assign a_e   = in_a[30:23];
    assign a_nan = (a_e == 8'hFF) && (in_a[22:0] != 23'd0);

    always_comb begin
        in_cls = CLS_OK;
        if (a_nan) begin
            in_cls = CLS_NAN;
        end else if (in_unsig) begin
            if (!a_s && a_e >= 8'd159)      in_cls = CLS_POS;
            else if (a_s && a_e >= 8'd127)  in_cls = CLS_NEG;
            else if (a_s)                   in_cls = CLS_NEG_LT1;
        end else begin
            if (!a_s && a_e >= 8'd158)      in_cls = CLS_POS;
            else if (a_s && a_e >= 8'd158 && in_a != 32'hCF00_0000) in_cls = CLS_NEG;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) sb_q[i] <= '0;
        end else begin
            vld_q   <= {vld_q[LATENCY-2:0], accept};
            sb_q[0] <= {in_unsig, in_cls, in_tag};
            for (int i = 1; i < LATENCY; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    assign push = vld_q[LATENCY-1];
    assign {p_uns, p_cls, p_tag} = sb_q[LATENCY-1];

    always_comb begin
        push_data = cvt_q[31:0];
        push_nv   = 1'b0;
        case (p_cls)
            CLS_NAN, CLS_POS: begin
                push_data = p_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
                push_nv   = 1'b1;
            end
            CLS_NEG: begin
                push_data = p_uns ? 32'h0000_0000 : 32'h8000_0000;
                push_nv   = 1'b1;
            end
            CLS_NEG_LT1: push_data = 32'h0000_0000;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {push_nv, push_data, p_tag};
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid & out_ready;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign out_data   = out_valid ? head[TAG_W +: 32] : 32'h0;
    assign out_nv     = out_valid & head[ENT_W-1];
    assign out_tag    = out_valid ? head[TAG_W-1:0] : '0;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ONE_C : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ONE_C : rd_ptr_q;
        count_d  = count_q;
        if (accept && !pop)      count_d = count_q + ONE_C;
        else if (!accept && pop) count_d = count_q - ONE_C;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!areset_n)
        !(push && (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])));
endmodule

// File: tb/tb_fp_cvt_w_stage.sv
// Bench for fp_cvt_w_stage: converter model, spec-level result/credit model, and directed vectors.
module tb_fp_cvt_w_stage;
    localparam int TAG_W = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             areset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = 32'h0;
    logic             in_unsig = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      cvt_a;
    logic [32:0]      cvt_q;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic             out_nv;
    logic [TAG_W-1:0] out_tag;

    logic [32:0] cv1 = '0, cv2 = '0, cv3 = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;

    typedef struct {
        logic [31:0]      data;
        logic             nv;
        logic [TAG_W-1:0] tag;
        int               t;
    } exp_t;
    exp_t exp_q[$];
    logic [32:0] mon_r;
    logic        mon_exp_v;

    always #5 clk = ~clk;

    fp_cvt_w_stage #(.LATENCY(LAT), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .areset_n(areset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_unsig(in_unsig), .in_tag(in_tag),
        .cvt_a(cvt_a), .cvt_q(cvt_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nv(out_nv), .out_tag(out_tag)
    );

    // Truncated (toward zero) integer value of an FP32, clamped to a huge magnitude when far out of range.
    function automatic longint trunc_val(input logic [31:0] a);
        int e;
        longint mag;
        e = int'(a[30:23]);
        if (e < 127) return 0;
        if (e >= 190) mag = longint'(1) <<< 62;
        else begin
            mag = longint'({1'b1, a[22:0]});
            if (e >= 150) mag = mag <<< (e - 150);
            else          mag = mag >>> (150 - e);
        end
        return a[31] ? -mag : mag;
    endfunction

    function automatic logic [32:0] conv33(input logic [31:0] a);
        longint v;
        logic [32:0] r;
        v = trunc_val(a);
        r = v[32:0];
        return r;
    endfunction

    // Expected {nv, data}: saturate the truncated value into the target integer range.
    function automatic logic [32:0] model_res(input logic [31:0] a, input logic u);
        longint v, lim_u, lim_sp, lim_sn;
        lim_u  = (longint'(1) <<< 32) - 1;
        lim_sp = (longint'(1) <<< 31) - 1;
        lim_sn = -(longint'(1) <<< 31);
        if (a[30:23] == 8'hFF && a[22:0] != 23'd0)
            return u ? {1'b1, 32'hFFFF_FFFF} : {1'b1, 32'h7FFF_FFFF};
        v = trunc_val(a);
        if (u) begin
            if (v > lim_u) return {1'b1, 32'hFFFF_FFFF};
            if (v < 0)     return {1'b1, 32'h0000_0000};
        end else begin
            if (v > lim_sp) return {1'b1, 32'h7FFF_FFFF};
            if (v < lim_sn) return {1'b1, 32'h8000_0000};
        end
        return {1'b0, v[31:0]};
    endfunction

    always @(posedge clk) begin
        cv1 <= conv33(cvt_a);
        cv2 <= cv1;
        cv3 <= cv2;
    end
    assign cvt_q = cv3;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every negedge the DUT is checked against the queue model.
    always @(negedge clk) begin
        if (!areset_n) begin
            exp_q.delete();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
        end else begin
            mon_exp_v = (exp_q.size() > 0) && (exp_q[0].t + LAT <= cyc);
            chk("mon_out_valid", 64'(out_valid), 64'(mon_exp_v));
            chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            if (out_valid && exp_q.size() > 0) begin
                chk("mon_data", 64'(out_data), 64'(exp_q[0].data));
                chk("mon_nv", 64'(out_nv), 64'(exp_q[0].nv));
                chk("mon_tag", 64'(out_tag), 64'(exp_q[0].tag));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                mon_r = model_res(in_a, in_unsig);
                exp_q.push_back('{mon_r[31:0], mon_r[32], in_tag, cyc + 1});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic u, input logic [TAG_W-1:0] tag);
        int n;
        bit acc;
        in_valid = 1'b1; in_a = a; in_unsig = u; in_tag = tag;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        chk("send_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [31:0] a, input logic u,
                           input logic [TAG_W-1:0] tag, input logic [31:0] exp_d, input logic exp_nv);
        int k;
        out_ready = 1'b1;
        send(a, u, tag);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        chk({name, "_lat"}, 64'(k), 64'd4);
        chk({name, "_data"}, 64'(out_data), 64'(exp_d));
        chk({name, "_nv"}, 64'(out_nv), 64'(exp_nv));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
        $display("op %s a=%h u=%0d -> data=%h nv=%0d tag=%0h", name, a, u, out_data, out_nv, out_tag);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, sent, n, p0, seen;

        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_nv", 64'(out_nv), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #2;
        areset_n = 1'b1;
        @(posedge clk); #1;

        chk("model_pin_3p7", 64'(model_res(32'h406C_CCCD, 1'b0)), 64'h0_0000_0003);
        chk("model_pin_4f7fffff_u", 64'(model_res(32'h4F7F_FFFF, 1'b1)), 64'h0_FFFF_FF00);
        chk("model_pin_neg3p5", 64'(model_res(32'hC060_0000, 1'b0)), 64'h0_FFFF_FFFD);

        run_one("s_3p7",      32'h406C_CCCD, 1'b0, 8'h01, 32'h0000_0003, 1'b0);
        run_one("s_qnan",     32'h7FC0_0000, 1'b0, 8'h02, 32'h7FFF_FFFF, 1'b1);
        run_one("s_min",      32'hCF00_0000, 1'b0, 8'h03, 32'h8000_0000, 1'b0);
        run_one("s_negovf",   32'hCF32_D05E, 1'b0, 8'h04, 32'h8000_0000, 1'b1);
        run_one("s_pinf",     32'h7F80_0000, 1'b0, 8'h05, 32'h7FFF_FFFF, 1'b1);
        run_one("s_neg3p5",   32'hC060_0000, 1'b0, 8'h06, 32'hFFFF_FFFD, 1'b0);
        run_one("s_subnorm",  32'h0000_0001, 1'b0, 8'h07, 32'h0000_0000, 1'b0);
        run_one("u_negp5",    32'hBF00_0000, 1'b1, 8'h08, 32'h0000_0000, 1'b0);
        run_one("u_neg1",     32'hBF80_0000, 1'b1, 8'h09, 32'h0000_0000, 1'b1);
        run_one("u_2p32",     32'h4F80_0000, 1'b1, 8'h0A, 32'hFFFF_FFFF, 1'b1);
        run_one("u_max",      32'h4F7F_FFFF, 1'b1, 8'h0B, 32'hFFFF_FF00, 1'b0);
        run_one("u_3p7",      32'h406C_CCCD, 1'b1, 8'h0C, 32'h0000_0003, 1'b0);

        // Backpressure: consumer stalled, producer always valid.
        out_ready = 1'b0;
        in_valid = 1'b1; in_unsig = 1'b0; in_a = 32'h4040_0000; in_tag = 8'h40;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            in_tag = 8'h40 + 8'(acc);
            in_a   = 32'h4040_0000 + 32'(acc) * 32'h0080_0000;
        end
        in_valid = 1'b0;
        chk("bp_accepts", 64'(acc), 64'(DEPTH));
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        p0 = pops;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_drained", 64'(pops - p0), 64'(DEPTH));
        chk("bp_model_empty", 64'(exp_q.size()), 64'd0);
        $display("backpressure: accepts=%0d drained=%0d", acc, pops - p0);

        // Streaming with the consumer always ready.
        p0 = pops;
        sent = 0; n = 0;
        in_valid = 1'b1; in_unsig = 1'b0; in_tag = 8'd0; in_a = 32'h3F80_0000;
        while (sent < 16 && n < 100) begin
            @(negedge clk);
            if (in_ready) sent++;
            @(posedge clk); #1;
            n++;
            in_tag = 8'(sent);
            in_a   = 32'h3F80_0000 + 32'(sent) * 32'h0080_0000;
        end
        in_valid = 1'b0;
        chk("stream_sent", 64'(sent), 64'd16);
        repeat (10) @(posedge clk);
        #1;
        chk("stream_pops", 64'(pops - p0), 64'd16);
        chk("stream_model_empty", 64'(exp_q.size()), 64'd0);
        $display("stream: sent=%0d in %0d cycles, results=%0d", sent, n, pops - p0);

        // Reset with one op in the FIFO and two in the converter pipe.
        out_ready = 1'b0;
        send(32'h4000_0000, 1'b0, 8'hA0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(32'h4040_0000, 1'b0, 8'hA1);
        send(32'h4080_0000, 1'b0, 8'hA2);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #1 areset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        @(posedge clk); #2;
        areset_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_no_output", 64'(seen), 64'd0);
        $display("reset mid-flight: stale outputs seen=%0d", seen);
        @(posedge clk); #1;
        run_one("post_rst", 32'h4120_0000, 1'b0, 8'h55, 32'h0000_000A, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
